// File: rtl/display_scan_mux.sv
// Multiplexed N-digit display scanner: descending column scan with blank gaps, digit skip mask and frame tick.
// Optional PWM brightness control is enabled by defining DISPLAY_SCAN_BRIGHTNESS_EN.
module display_scan_mux #(
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int SEG_W        = 8,
    parameter int ACTIVE_LOW   = 1,
    localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_DIGITS-1:0]       digit_mask,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [3:0]                  brightness,
`endif
    output logic [NUM_DIGITS-1:0]       column_scan_signal,
    output logic [SEG_W-1:0]            seg_out,
    output logic [DIG_W-1:0]            cur_digit,
    output logic                        frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] COL_OFF    = {NUM_DIGITS{ACTIVE_LOW != 0}};
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             need_sel;
    logic             incl_found;
    logic             excl_found;
    logic [DIG_W-1:0] incl_idx;
    logic [DIG_W-1:0] excl_idx;
    logic [DIG_W-1:0] sel_idx;
    logic             sel_ok;
    logic             blank_done;
    logic             lit_next;

    function automatic logic [NUM_DIGITS-1:0] col_drive(input logic [DIG_W-1:0] idx);
        return (NUM_DIGITS'(1) << idx) ^ COL_OFF;
    endfunction

    function automatic logic [SEG_W-1:0] seg_drive(input logic [DIG_W-1:0]        idx,
                                                   input logic [NUM_DIGITS*SEG_W-1:0] data);
        return data[32'(idx)*SEG_W +: SEG_W] ^ SEG_OFF;
    endfunction

    // Inclusive search starts at cur_digit itself; exclusive search starts one below and
    // ends on cur_digit, so a lone enabled digit re-selects itself.
    always_comb begin
        int unsigned ji;
        int unsigned je;
        incl_found = 1'b0;
        excl_found = 1'b0;
        incl_idx   = '0;
        excl_idx   = '0;
        ji         = 0;
        je         = 0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            ji = (32'(cur_digit) + NUM_DIGITS - k) % NUM_DIGITS;
            if (!incl_found && digit_mask[DIG_W'(ji)]) begin
                incl_found = 1'b1;
                incl_idx   = DIG_W'(ji);
            end
        end
        for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
            je = (32'(cur_digit) + NUM_DIGITS - k) % NUM_DIGITS;
            if (!excl_found && digit_mask[DIG_W'(je)]) begin
                excl_found = 1'b1;
                excl_idx   = DIG_W'(je);
            end
        end
    end

    assign sel_idx    = need_sel ? incl_idx : cur_digit;
    assign sel_ok     = !need_sel || incl_found;
    assign blank_done = (cnt >= BLANK_LAST);

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0] bright_cnt;
    logic [3:0] bright_next;
    assign bright_next = bright_cnt + 4'd1;
    assign lit_next    = (bright_next <= brightness);
`else
    assign lit_next = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            need_sel           <= 1'b1;
            cur_digit          <= DIG_W'(NUM_DIGITS - 1);
            column_scan_signal <= COL_OFF;
            seg_out            <= SEG_OFF;
            frame_tick         <= 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
            bright_cnt         <= '0;
`endif
        end else begin
            frame_tick <= 1'b0;
            if (!en) begin
                state              <= IDLE;
                cnt                <= '0;
                column_scan_signal <= COL_OFF;
                seg_out            <= SEG_OFF;
            end else begin
                unique case (state)
                    IDLE: begin
                        state    <= BLANK;
                        cnt      <= '0;
                        need_sel <= 1'b1;
                    end
                    BLANK: begin
                        // With an all-zero mask after the gap, wait here until a digit is enabled.
                        if (!blank_done) begin
                            cnt <= cnt + 1'b1;
                        end else if (sel_ok) begin
                            state              <= DRIVE;
                            cnt                <= '0;
                            need_sel           <= 1'b0;
                            cur_digit          <= sel_idx;
                            column_scan_signal <= col_drive(sel_idx);
                            seg_out            <= seg_drive(sel_idx, seg_data);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                            bright_cnt         <= '0;
`endif
                        end
                    end
                    DRIVE: begin
                        if (cnt == DWELL_LAST) begin
                            cnt <= '0;
                            if (excl_found) begin
                                cur_digit  <= excl_idx;
                                frame_tick <= (excl_idx >= cur_digit);
                            end else begin
                                need_sel <= 1'b1;
                            end
                            if (BLANK_CYCLES == 0 && excl_found) begin
                                state              <= DRIVE;
                                column_scan_signal <= col_drive(excl_idx);
                                seg_out            <= seg_drive(excl_idx, seg_data);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                                bright_cnt         <= '0;
`endif
                            end else begin
                                state              <= BLANK;
                                column_scan_signal <= COL_OFF;
                                seg_out            <= SEG_OFF;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                            bright_cnt <= bright_next;
`endif
                            if (lit_next) begin
                                column_scan_signal <= col_drive(cur_digit);
                                seg_out            <= seg_drive(cur_digit, seg_data);
                            end else begin
                                column_scan_signal <= COL_OFF;
                                seg_out            <= SEG_OFF;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a slot-arithmetic reference model predicts every output cycle.
module tb_display_scan_mux;
    localparam int N  = 6;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    digit_mask;
    logic [N*SW-1:0] seg_data;
    logic [N-1:0]    column_scan_signal;
    logic [SW-1:0]   seg_out;
    logic [2:0]      cur_digit;
    logic            frame_tick;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0]      brightness = 4'hF;
`endif

    display_scan_mux #(
        .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .SEG_W(SW), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask), .seg_data(seg_data),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .column_scan_signal(column_scan_signal), .seg_out(seg_out),
        .cur_digit(cur_digit), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [N-1:0]  col;
        logic [SW-1:0] seg;
        logic [2:0]    cur;
        logic          ft;
        bit            last;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp;
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b1;

    // Model: either "off" (all inactive, fixed index) or a scan segment described by its
    // start cycle, leading blank count and the descending list of enabled digits.
    bit m_on;
    int m_c0, m_l0, m_cur0, m_cnt, m_i0, off_cur;
    int m_list[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic start_seg(input logic [N-1:0] m, input int l0);
        m_cnt = 0;
        for (int i = N - 1; i >= 0; i--)
            if (m[i]) begin
                m_list[m_cnt] = i;
                m_cnt++;
            end
        m_i0 = 0;
        for (int i = m_cnt - 1; i >= 0; i--)
            if (m_list[i] <= off_cur) m_i0 = i;
        m_c0   = int'(cyc);
        m_l0   = l0;
        m_cur0 = off_cur;
        m_on   = 1'b1;
    endtask

    function automatic exp_t model(input int unsigned t, input logic [N*SW-1:0] sd);
        exp_t e;
        int j, r, s, p, d;
        bit act;
        e.cyc = t; e.col = '1; e.seg = '1; e.ft = 1'b0; e.cur = 3'(off_cur); e.last = 1'b0;
        if (!m_on) return e;
        j = int'(t) - m_c0;
        if (j <= m_l0) begin
            e.cur = 3'(m_cur0);
            return e;
        end
        r = j - m_l0 - 1;
        p = 0;
        if (r < DW) begin
            s = 0; act = 1'b1; e.last = (r == DW - 1);
        end else begin
            r = r - DW;
            s = 1 + r / (BL + DW);
            p = r % (BL + DW);
            act = (p >= BL);
            e.last = (p == BL + DW - 1);
        end
        d = m_list[(m_i0 + s) % m_cnt];
        e.cur = 3'(d);
        if (s > 0 && p == 0) e.ft = (d >= m_list[(m_i0 + s - 1) % m_cnt]);
        if (act) begin
            e.col = ~(6'(1) << d);
            e.seg = ~sd[d*SW +: SW];
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        seg_data[31:0]  = $urandom;
        seg_data[47:32] = 16'($urandom);
        e = model(cyc + 1, seg_data);
        q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                chk("missed_slot", 64'(mon_e.cyc), 64'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_e = q.pop_front();
                chk("column", 64'(column_scan_signal), 64'(mon_e.col));
                chk("seg_out", 64'(seg_out), 64'(mon_e.seg));
                chk("cur_digit", 64'(cur_digit), 64'(mon_e.cur));
                chk("frame_tick", 64'(frame_tick), 64'(mon_e.ft));
            end
        end
    end

    initial begin
        logic [N-1:0] m;
        int guard;
        rst_n = 1'b0; en = 1'b0; digit_mask = '1; seg_data = '0;
        m_on = 1'b0; off_cur = N - 1;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int sg = 0; sg < 14; sg++) begin
            case (sg)
                0:       m = 6'b111111;
                1:       m = 6'b100101;
                2:       m = 6'b001000;
                default: begin
                    m = 6'($urandom);
                    if (m == '0) m = 6'b010000;
                end
            endcase
            en = 1'b1;
            digit_mask = m;
            start_seg(m, BL);
            repeat ((sg == 0) ? 80 : $urandom_range(12, 60)) step();
            if (sg % 3 == 1) begin
                guard = 0;
                while (!last_exp.last && guard < 50) begin
                    step();
                    guard++;
                end
                digit_mask = '0;
                off_cur = int'(last_exp.cur);
                m_on = 1'b0;
                repeat ($urandom_range(3, 8)) step();
                m = 6'($urandom);
                if (m == '0) m = 6'b000001;
                digit_mask = m;
                start_seg(m, 0);
                repeat ($urandom_range(15, 40)) step();
            end
            en = 1'b0;
            off_cur = int'(last_exp.cur);
            m_on = 1'b0;
            repeat ($urandom_range(1, 4)) step();
        end

        // Asynchronous reset in the middle of a drive phase.
        en = 1'b1;
        digit_mask = '1;
        start_seg('1, BL);
        repeat (BL + 2) step();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_column", 64'(column_scan_signal), 64'h3F);
        chk("rst_seg_out", 64'(seg_out), 64'hFF);
        chk("rst_cur_digit", 64'(cur_digit), 64'd5);
        chk("rst_frame_tick", 64'(frame_tick), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised multiplexed-display scanner for the digital clock; successor to the fixed 6-column rotating scan.
- Generalises to N digits with a configurable dwell time per digit and anti-ghosting blank gaps.
- Supports a digit-enable mask with skip-over and an output polarity parameter.
- Also muxes per-digit segment data to a shared segment bus and emits a frame tick; sits between the time/format logic and the LED/7-seg pads.

Parameters:
NUM_DIGITS, 6, number of digit columns (>=1)
DWELL_CYCLES, 1000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 16, clk cycles all columns are off between digits (0 = no gap)
SEG_W, 8, segment bus width per digit
ACTIVE_LOW, 1, 1: active column/segment driven 0; 0: driven 1

Ports:
clk  input  1  clock
rst_n  input  1  reset
en  input  1  scan enable
digit_mask  input  NUM_DIGITS  1 = digit participates in scan
seg_data  input  NUM_DIGITS*SEG_W  flat segment data, digit i at [i*SEG_W +: SEG_W], 1 = lit
column_scan_signal  output  NUM_DIGITS  one-hot (polarity per ACTIVE_LOW) column drive
seg_out  output  SEG_W  segment drive for active digit (polarity per ACTIVE_LOW)
cur_digit  output  $clog2(NUM_DIGITS) (min 1)  index of digit currently selected
frame_tick  output  1  one-cycle pulse on scan wrap

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All outputs are registered.
- Reset values:
  - state IDLE; cur_digit = NUM_DIGITS-1.
  - column_scan_signal all inactive (all 1s if ACTIVE_LOW).
  - seg_out inactive (all 1s if ACTIVE_LOW); frame_tick 0.
  - dwell/blank counter 0.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: outputs inactive. When en=1, go to BLANK on the next cycle.
  - BLANK: all columns and segments inactive for BLANK_CYCLES cycles, then DRIVE. If BLANK_CYCLES=0, go straight to DRIVE.
  - DRIVE: for exactly DWELL_CYCLES cycles, column cur_digit is active and seg_out follows seg_data slice cur_digit. seg_out is sampled every cycle with 1-cycle register latency and inverted if ACTIVE_LOW. At the end of DRIVE, advance cur_digit and return to BLANK.
- Scan order is descending with wrap (N-1, N-2, ..., 0, N-1), matching the legacy right-rotate order.
- Advance selects the next index below cur_digit (with wrap) whose digit_mask bit is 1, using the mask sampled at the advance cycle.
- frame_tick = 1 for the single cycle in which the advance produces new index >= old index. This covers wrap and the single-enabled-digit case.
- Masked digit currently driving: the dwell completes; the mask affects only the next selection.
- digit_mask = 0: after the current dwell, remain in BLANK indefinitely with outputs inactive and no frame_tick. When any bit is set, the next selection resumes from cur_digit and drives the first enabled digit found searching downward from cur_digit inclusive.
- IDLE entry from en=1 and the first selection also skip masked digits: the first digit driven is the first enabled index found downward from cur_digit inclusive.
- en falling in BLANK or DRIVE: the next cycle is IDLE with outputs inactive. The counter is cleared and cur_digit is retained. Re-enable restarts with BLANK on the same cur_digit.
- At no cycle may more than one column be active. Column and segment changes always pass through at least BLANK_CYCLES inactive cycles.
- Dwell period per enabled digit = BLANK_CYCLES + DWELL_CYCLES. The frame period is that value times the number of enabled digits.

Optional Feature:
- Macro: DISPLAY_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input brightness[3:0].
  - A 4-bit counter clears on DRIVE entry and increments each DRIVE cycle (wrapping mod 16).
  - The column and segments are active only while counter <= brightness; otherwise they are inactive.
  - brightness=15 gives full on; brightness=0 gives 1/16 duty.
- When undefined: no port and no counter; the column is active for the whole DRIVE.

Test Plan:
All scenarios use NUM_DIGITS=6, DWELL_CYCLES=4, BLANK_CYCLES=2, SEG_W=8, ACTIVE_LOW=1.
1. Reset asserted mid-DRIVE -> immediately column_scan_signal=6'b111111, seg_out=8'hFF, cur_digit=5, frame_tick=0.
2. en=1, mask=6'b111111 -> 2 cycles 111111, 4 cycles 011111, 2 cycles 111111, 4 cycles 101111, ..., 4 cycles 111110. frame_tick pulses on the advance from 0 to 5; frame period = 36 cycles.
3. mask=6'b100101 -> column sequence 011111, 111011, 111110, 011111. frame_tick occurs once per 18 cycles; no other column patterns appear.
4. seg_data digit 5 = 8'h3F during its DRIVE -> seg_out=8'hC0 for all 4 drive cycles, and 8'hFF during blanks.
5. en dropped in 2nd DRIVE cycle of digit 4 -> next cycle all 1s, IDLE. Re-enable gives 2 blank cycles, then 101111 for a full 4 cycles.
6. Macro on, DWELL_CYCLES=16, brightness=3 -> within each DRIVE the column is 0 for cycles 0-3 and 1 for cycles 4-15. With mask=0, columns stay 111111 and there is no frame_tick.
